// File: rtl/spi_pi_mem_bridge.sv
// SPI mode-0 slave that lets the Raspberry Pi host stream 32-bit words into and out of
// port s2 of the shared Nios/Pi on-chip RAM, with address auto-increment.
module spi_pi_mem_bridge #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  spi_clk,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_clken,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  xfer_done
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RD   = 2'd3;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_prev_r;
    logic                   cs_prev_r;

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [6:0]        cmd_shift_r;
    logic [DATA_W-2:0] wr_shift_r;
    logic [DATA_W-1:0] rd_buf_r;
    logic [DATA_W-1:0] out_shift_r;
    logic              word_start_r;
    logic              rd_capture_r;

    logic              sclk_s;
    logic              cs_s;
    logic              mosi_s;
    logic              rise_s;
    logic              fall_s;
    logic              cs_fall_s;
    logic [7:0]        cmd_byte_s;
    logic [DATA_W-1:0] wr_word_s;

    assign sclk_s     = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s       = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign rise_s     = sclk_s & ~sclk_prev_r;
    assign fall_s     = ~sclk_s & sclk_prev_r;
    // cs history resets low so a select held low through reset never counts as a new frame
    assign cs_fall_s  = cs_prev_r & ~cs_s;
    assign cmd_byte_s = {cmd_shift_r, mosi_s};
    assign wr_word_s  = {wr_shift_r, mosi_s};

    // Synchronise the asynchronous SPI pins and keep one cycle of history for edge detection
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync_r <= '0;
            cs_sync_r   <= '0;
            mosi_sync_r <= '0;
            sclk_prev_r <= 1'b0;
            cs_prev_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_r <= sclk_s;
            cs_prev_r   <= cs_s;
        end
    end

    // Transfer FSM, RAM strobes and MISO shifter
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r        <= ST_IDLE;
            bit_cnt_r      <= '0;
            cmd_shift_r    <= 7'd0;
            wr_shift_r     <= '0;
            rd_buf_r       <= '0;
            out_shift_r    <= '0;
            word_start_r   <= 1'b0;
            rd_capture_r   <= 1'b0;
            spi_miso       <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_clken      <= 1'b1;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            xfer_done      <= 1'b0;
        end else begin
            mem_clken      <= 1'b1;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= '0;
            xfer_done      <= 1'b0;
            // RAM returns read data one cycle after the read strobe
            rd_capture_r   <= mem_chipselect & ~mem_write;
            if (rd_capture_r) begin
                rd_buf_r <= mem_readdata;
            end
            if (mem_chipselect && mem_write) begin
                mem_address <= mem_address + ADDR_W'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    spi_miso <= 1'b0;
                    if (cs_fall_s) begin
                        bit_cnt_r <= '0;
                        state_r   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    spi_miso <= 1'b0;
                    if (cs_s) begin
                        state_r <= ST_IDLE;
                    end else if (rise_s) begin
                        cmd_shift_r <= cmd_byte_s[6:0];
                        if (bit_cnt_r == CNT_W'(7)) begin
                            bit_cnt_r   <= '0;
                            mem_address <= ADDR_W'(cmd_byte_s[6:0]);
                            if (cmd_byte_s[7]) begin
                                state_r <= ST_WR;
                            end else begin
                                mem_chipselect <= 1'b1;
                                word_start_r   <= 1'b1;
                                state_r        <= ST_RD;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_WR: begin
                    if (cs_s) begin
                        xfer_done <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (rise_s) begin
                        wr_shift_r <= wr_word_s[DATA_W-2:0];
                        if (bit_cnt_r == CNT_W'(DATA_W-1)) begin
                            bit_cnt_r      <= '0;
                            mem_chipselect <= 1'b1;
                            mem_write      <= 1'b1;
                            mem_byteenable <= '1;
                            mem_writedata  <= wr_word_s;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_RD: begin
                    if (cs_s) begin
                        spi_miso  <= 1'b0;
                        xfer_done <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (rise_s) begin
                        if (bit_cnt_r == CNT_W'(DATA_W-1)) begin
                            // prefetch the next word so the stream has no gap
                            bit_cnt_r      <= '0;
                            mem_address    <= mem_address + ADDR_W'(1);
                            mem_chipselect <= 1'b1;
                            word_start_r   <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end
                    end else if (fall_s) begin
                        if (word_start_r) begin
                            spi_miso     <= rd_buf_r[DATA_W-1];
                            out_shift_r  <= {rd_buf_r[DATA_W-2:0], 1'b0};
                            word_start_r <= 1'b0;
                        end else begin
                            spi_miso    <= out_shift_r[DATA_W-1];
                            out_shift_r <= {out_shift_r[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        spi_miso <= spi_miso;
                    end
                end
                default: begin
                    spi_miso <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pi_mem_bridge.sv
// Self-checking bench: drives SPI frames as a host would and compares RAM strobes and
// MISO words against a transaction-level memory model.
module tb_spi_pi_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_clk;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic [6:0]  mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = 32'd0;
    logic        xfer_done;

    always #5 clk = ~clk;

    spi_pi_mem_bridge dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .spi_clk        (spi_clk),
        .spi_cs         (spi_cs),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .xfer_done      (xfer_done)
    );

    int checks = 0;
    int errors = 0;
    int half   = 4;

    logic [31:0] ram     [0:127];
    logic [31:0] ref_mem [0:127];
    logic [31:0] tx_words[0:7];
    logic [31:0] rx_words[0:7];
    logic        cmd_miso;

    logic [6:0]  st_addr[$];
    logic [31:0] st_data[$];
    logic [3:0]  st_be[$];
    int          cs_cnt = 0;
    int          xd_cnt = 0;
    int          be_err = 0;

    // Bus-side RAM of the SoPC port and activity monitor
    always @(posedge clk) begin
        if (mem_chipselect) begin
            cs_cnt++;
            if (mem_write) begin
                ram[mem_address] <= mem_writedata;
                st_addr.push_back(mem_address);
                st_data.push_back(mem_writedata);
                st_be.push_back(mem_byteenable);
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
        if (!mem_write && mem_byteenable != 4'h0) be_err++;
        if (xfer_done) xd_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        st_addr.delete();
        st_data.delete();
        st_be.delete();
        cs_cnt = 0;
        xd_cnt = 0;
    endtask

    task automatic cs_low();
        spi_clk = 1'b0;
        spi_cs  = 1'b0;
        wait_clk(half);
    endtask

    task automatic cs_high();
        wait_clk(half);
        spi_cs = 1'b1;
        wait_clk(12);
    endtask

    task automatic bit_xfer(input logic b, output logic m);
        spi_mosi = b;
        wait_clk(half);
        m = spi_miso;
        spi_clk = 1'b1;
        wait_clk(half);
        spi_clk = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd);
        logic m;
        cmd_miso = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(cmd[i], m);
            cmd_miso = cmd_miso | m;
        end
    endtask

    task automatic spi_transfer(input logic [7:0] cmd, input int nw);
        logic m;
        clear_mon();
        cs_low();
        send_cmd(cmd);
        for (int w = 0; w < nw; w++) begin
            for (int b = 31; b >= 0; b--) begin
                bit_xfer(tx_words[w][b], m);
                rx_words[w][b] = m;
            end
        end
        cs_high();
    endtask

    // Compare recorded write strobes with the words sent, then apply them to the model
    task automatic verify_writes(input string tag, input logic [6:0] a, input int nw);
        logic [6:0] ea;
        check_eq({tag, "_nwr"}, 64'(st_addr.size()), 64'(nw));
        for (int i = 0; i < nw && i < st_addr.size(); i++) begin
            ea = a + 7'(i);
            check_eq({tag, "_addr"}, 64'(st_addr[i]), 64'(ea));
            check_eq({tag, "_data"}, 64'(st_data[i]), 64'(tx_words[i]));
            check_eq({tag, "_be"},   64'(st_be[i]),   64'(4'hF));
        end
        for (int i = 0; i < nw; i++) ref_mem[(int'(a) + i) % 128] = tx_words[i];
        check_eq({tag, "_xfer_done"}, 64'(xd_cnt), 64'd1);
    endtask

    task automatic verify_reads(input string tag, input logic [6:0] a, input int nw);
        for (int i = 0; i < nw; i++)
            check_eq({tag, "_word"}, 64'(rx_words[i]), 64'(ref_mem[(int'(a) + i) % 128]));
        check_eq({tag, "_nwr"}, 64'(st_addr.size()), 64'd0);
        check_eq({tag, "_cmd_miso"}, 64'(cmd_miso), 64'd0);
        check_eq({tag, "_xfer_done"}, 64'(xd_cnt), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"}, 64'(spi_miso), 64'd0);
        check_eq({tag, "_cs"},   64'(mem_chipselect), 64'd0);
        check_eq({tag, "_wr"},   64'(mem_write), 64'd0);
        check_eq({tag, "_addr"}, 64'(mem_address), 64'd0);
        check_eq({tag, "_wdat"}, 64'(mem_writedata), 64'd0);
        check_eq({tag, "_be"},   64'(mem_byteenable), 64'd0);
        check_eq({tag, "_clken"}, 64'(mem_clken), 64'd1);
        check_eq({tag, "_xd"},   64'(xfer_done), 64'd0);
    endtask

    initial begin
        logic       m;
        logic       dir;
        logic [6:0] ra;
        int         nw;
        int         mism;

        for (int i = 0; i < 128; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        rst_n    = 1'b0;
        spi_clk  = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clk(10);

        // 1: two-word write at 0x85
        tx_words[0] = 32'hDEADBEEF;
        tx_words[1] = 32'h01234567;
        spi_transfer(8'h85, 2);
        verify_writes("t1", 7'd5, 2);

        // 2: streamed read of preloaded words
        ram[3] = 32'hCAFEF00D; ref_mem[3] = 32'hCAFEF00D;
        ram[4] = 32'h55AA55AA; ref_mem[4] = 32'h55AA55AA;
        spi_transfer(8'h03, 2);
        check_eq("t2_w0", 64'(rx_words[0]), 64'h0000_0000_CAFE_F00D);
        check_eq("t2_w1", 64'(rx_words[1]), 64'h0000_0000_55AA_55AA);
        verify_reads("t2", 7'd3, 2);

        // 3: address wrap 127 -> 0
        tx_words[0] = 32'h11111111;
        tx_words[1] = 32'h22222222;
        spi_transfer(8'hFF, 2);
        verify_writes("t3", 7'd127, 2);

        // 4: abort after 20 data bits of a write
        clear_mon();
        cs_low();
        send_cmd(8'h82);
        for (int i = 0; i < 20; i++) bit_xfer(1'($urandom_range(0, 1)), m);
        cs_high();
        check_eq("t4_nwr", 64'(st_addr.size()), 64'd0);
        check_eq("t4_xd", 64'(xd_cnt), 64'd1);
        check_eq("t4_miso", 64'(spi_miso), 64'd0);

        // 5: short command then a clean read of addr 0
        clear_mon();
        cs_low();
        for (int i = 0; i < 5; i++) bit_xfer(1'(i == 0), m);
        cs_high();
        check_eq("t5_access", 64'(cs_cnt), 64'd0);
        check_eq("t5_xd", 64'(xd_cnt), 64'd0);
        spi_transfer(8'h00, 1);
        check_eq("t5_w0", 64'(rx_words[0]), 64'h0000_0000_2222_2222);
        verify_reads("t5", 7'd0, 1);

        // 6: reset during bit 10 of a read, then a fresh write to addr 9
        clear_mon();
        cs_low();
        send_cmd(8'h04);
        for (int i = 0; i < 9; i++) bit_xfer(1'b0, m);
        spi_mosi = 1'b0;
        wait_clk(2);
        spi_clk = 1'b1;
        wait_clk(2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        spi_clk = 1'b0;
        spi_cs  = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        check_eq("t6_xd", 64'(xd_cnt), 64'd0);
        tx_words[0] = 32'hA5A5A5A5;
        spi_transfer(8'h89, 1);
        verify_writes("t6", 7'd9, 1);
        spi_transfer(8'h09, 1);
        verify_reads("t6rd", 7'd9, 1);

        // Randomised frames at varying SCLK rates
        for (int k = 0; k < 10; k++) begin
            half = $urandom_range(4, 6);
            dir  = 1'($urandom_range(0, 1));
            ra   = 7'($urandom_range(120, 127 + 8) % 128);
            nw   = $urandom_range(0, 3);
            for (int i = 0; i < nw; i++) tx_words[i] = $urandom;
            spi_transfer({dir, ra}, nw);
            if (dir) verify_writes("rnd_wr", ra, nw);
            else     verify_reads("rnd_rd", ra, nw);
        end

        mism = 0;
        for (int i = 0; i < 128; i++) if (ram[i] !== ref_mem[i]) mism++;
        check_eq("ram_final", 64'(mism), 64'd0);
        check_eq("be_idle_zero", 64'(be_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
